seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking between digits,
// optional leading-zero suppression and a double-buffered load path that only
// swaps in new display data at a frame boundary (or at once while disabled).
module seg_scan_ctrl #(
    parameter int DIV_MAX   = 49999,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lz_en,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int PRE_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t             state_r, state_n_s;
    logic [1:0]         idx_r, idx_n_s;
    logic [BLK_W-1:0]   blk_cnt_r, blk_cnt_n_s;
    logic [PRE_W-1:0]   pre_cnt_r, pre_cnt_n_s;
    logic [15:0]        disp_r, disp_n_s;
    logic [15:0]        pend_r, pend_n_s;
    logic               pend_full_r, pend_full_n_s;
    logic [3:0]         an_r, an_n_s;
    logic [6:0]         seg_r, seg_n_s;
    logic               frame_done_r, frame_done_n_s;
    logic               commit_s;
    logic               xfer_s;
    logic [3:0]         nib_s;

    // Hex digit to {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h27;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            4'hF:    g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // True when digit k and every digit above it are zero; digit 0 never blanks.
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] k);
        logic z;
        case (k)
            2'd3:    z = (d[15:12] == 4'h0);
            2'd2:    z = (d[15:8]  == 8'h00);
            2'd1:    z = (d[15:4]  == 12'h000);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    // Scan sequencing: blank/show dwell counters, digit index, frame boundary.
    always_comb begin
        state_n_s      = state_r;
        idx_n_s        = idx_r;
        blk_cnt_n_s    = blk_cnt_r;
        pre_cnt_n_s    = pre_cnt_r;
        frame_done_n_s = 1'b0;
        commit_s       = 1'b0;
        if (!en) begin
            state_n_s   = ST_BLANK;
            idx_n_s     = 2'd0;
            blk_cnt_n_s = '0;
            pre_cnt_n_s = '0;
            commit_s    = pend_full_r;
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (blk_cnt_r == BLK_W'(BLANK_CYC - 1)) begin
                        state_n_s   = ST_SHOW;
                        pre_cnt_n_s = '0;
                        blk_cnt_n_s = '0;
                    end else begin
                        blk_cnt_n_s = blk_cnt_r + BLK_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (pre_cnt_r == PRE_W'(DIV_MAX)) begin
                        state_n_s   = ST_BLANK;
                        idx_n_s     = idx_r + 2'd1;
                        blk_cnt_n_s = '0;
                        pre_cnt_n_s = '0;
                        if (idx_r == 2'd3) begin
                            frame_done_n_s = 1'b1;
                            commit_s       = pend_full_r;
                        end else begin
                            frame_done_n_s = 1'b0;
                        end
                    end else begin
                        pre_cnt_n_s = pre_cnt_r + PRE_W'(1);
                    end
                end
                default: begin
                    state_n_s   = ST_BLANK;
                    idx_n_s     = 2'd0;
                    blk_cnt_n_s = '0;
                    pre_cnt_n_s = '0;
                end
            endcase
        end
    end

    // Load buffer: accept only into an empty pending slot, commit never collides.
    always_comb begin
        xfer_s        = ld_valid && !pend_full_r;
        disp_n_s      = commit_s ? pend_r : disp_r;
        pend_n_s      = xfer_s ? ld_data : pend_r;
        if (xfer_s) begin
            pend_full_n_s = 1'b1;
        end else if (commit_s) begin
            pend_full_n_s = 1'b0;
        end else begin
            pend_full_n_s = pend_full_r;
        end
    end

    // Output decode from the next state so pins change on the transition edge.
    always_comb begin
        an_n_s  = 4'b1111;
        seg_n_s = 7'h00;
        nib_s   = disp_n_s[{idx_n_s, 2'b00} +: 4];
        if (state_n_s == ST_SHOW) begin
            an_n_s = ~(4'b0001 << idx_n_s);
            if (lz_en && lead_zero(disp_n_s, idx_n_s)) begin
                seg_n_s = 7'h00;
            end else begin
                seg_n_s = hex_glyph(nib_s);
            end
        end else begin
            an_n_s  = 4'b1111;
            seg_n_s = 7'h00;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_BLANK;
            idx_r     <= 2'd0;
            blk_cnt_r <= '0;
            pre_cnt_r <= '0;
        end else begin
            state_r   <= state_n_s;
            idx_r     <= idx_n_s;
            blk_cnt_r <= blk_cnt_n_s;
            pre_cnt_r <= pre_cnt_n_s;
        end
    end

    // Data buffers and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r       <= 16'h0000;
            pend_r       <= 16'h0000;
            pend_full_r  <= 1'b0;
            an_r         <= 4'b1111;
            seg_r        <= 7'h00;
            frame_done_r <= 1'b0;
        end else begin
            disp_r       <= disp_n_s;
            pend_r       <= pend_n_s;
            pend_full_r  <= pend_full_n_s;
            an_r         <= an_n_s;
            seg_r        <= seg_n_s;
            frame_done_r <= frame_done_n_s;
        end
    end

    assign ld_ready   = ~pend_full_r;
    assign an         = an_r;
    assign seg        = seg_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with short dwell times. A frame-position model
// predicts every cycle's outputs into a queue; a table of display values adds
// per-digit glyph checks, and hand sequences cover back-to-back loads,
// disable mid-frame and asynchronous reset.
module tb_seg_scan_ctrl;

    localparam int DM   = 3;
    localparam int BC   = 2;
    localparam int SLOT = BC + DM + 1;
    localparam int FR   = 4 * SLOT;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        lz_en;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_ctrl #(.DIV_MAX(DM), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .lz_en      (lz_en),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
    } exp_t;

    typedef struct packed {
        logic [15:0]     data;
        logic            lz;
        logic [3:0][6:0] segs;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[6];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position inside the frame plus the load buffers.
    int          m_p;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_full;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic model_reset();
        m_p    = 0;
        m_disp = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;
        sbq.delete();
    endtask

    // Predict the outputs after the coming edge from the inputs now driven.
    task automatic model_push();
        exp_t        e;
        logic        commit;
        logic        xfer;
        int          d;
        int          q;
        logic [15:0] sh;
        logic [3:0]  one;
        commit = m_full && (!en || (m_p == FR - 1));
        xfer   = ld_valid && !m_full;
        e.fd   = en && (m_p == FR - 1);
        if (commit) m_disp = m_pend;
        if (xfer) begin
            m_pend = ld_data;
            m_full = 1'b1;
        end else if (commit) begin
            m_full = 1'b0;
        end
        m_p = en ? (m_p + 1) % FR : 0;
        d   = m_p / SLOT;
        q   = m_p % SLOT;
        one = 4'b0001;
        if (q >= BC) begin
            e.an = ~(one << d);
            sh   = m_disp >> (4 * d);
            if (lz_en && d > 0 && sh == 16'h0000) e.seg = 7'h00;
            else                                  e.seg = GLYPH[sh[3:0]];
        end else begin
            e.an  = 4'b1111;
            e.seg = 7'h00;
        end
        e.rdy = !m_full;
        sbq.push_back(e);
    endtask

    // One clock: predict, clock, then compare the popped expectation.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("an",         an,         e.an);
        check("seg",        seg,        e.seg);
        check("frame_done", frame_done, e.fd);
        check("ld_ready",   ld_ready,   e.rdy);
    endtask

    task automatic advance_to(input int pos);
        int n;
        n = 0;
        while (m_p != pos && n < 2 * FR) begin
            step();
            n++;
        end
        if (m_p != pos) check("advance_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seen [4];
        logic       pre;
        int         n;

        tbl[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        tbl[1] = '{16'h0070, 1'b1, {7'h00, 7'h00, 7'h27, 7'h3F}};
        tbl[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
        tbl[3] = '{16'hBEEF, 1'b0, {7'h7C, 7'h79, 7'h79, 7'h71}};
        tbl[4] = '{16'h00A0, 1'b0, {7'h3F, 7'h3F, 7'h77, 7'h3F}};
        tbl[5] = '{16'h8005, 1'b1, {7'h7F, 7'h3F, 7'h3F, 7'h6D}};

        rst_n    = 1'b0;
        en       = 1'b0;
        lz_en    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        #12;
        check("rst_an",  an,         4'b1111);
        check("rst_seg", seg,        7'h00);
        check("rst_fd",  frame_done, 1'b0);
        check("rst_rdy", ld_ready,   1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        model_reset();

        // Table: load, wait for the boundary commit, then inspect one frame.
        for (int v = 0; v < 6; v++) begin
            lz_en    = tbl[v].lz;
            ld_valid = 1'b1;
            ld_data  = tbl[v].data;
            step();
            ld_valid = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (!frame_done && n < FR + 4);
            if (!frame_done) check("commit_timeout", 32'd0, 32'd1);
            for (int k = 0; k < 4; k++) seen[k] = 8'hFF;
            for (int i = 0; i < FR; i++) begin
                step();
                for (int k = 0; k < 4; k++)
                    if (!an[k] && an != 4'b1111) seen[k] = {1'b0, seg};
            end
            for (int k = 0; k < 4; k++)
                check("tbl_seg", seen[k], {1'b0, tbl[v].segs[k]});
        end

        // Back-to-back loads: second one held off until the first commits.
        lz_en    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 16'hA000;
        step();
        check("b2b_ready_low", ld_ready, 1'b0);
        ld_data = 16'hBEEF;
        n = 0;
        do begin
            pre = ld_ready;
            step();
            n++;
        end while (!pre && n < 2 * FR);
        ld_valid = 1'b0;
        if (!pre) check("b2b_timeout", 32'd0, 32'd1);
        check("b2b_pending", ld_ready, 1'b0);
        for (int i = 0; i < 2 * FR; i++) step();

        // Disable during digit 2 with a load pending.
        advance_to(0);
        ld_valid = 1'b1;
        ld_data  = 16'h5678;
        step();
        ld_valid = 1'b0;
        advance_to(2 * SLOT + BC);
        check("dis_pre_an",  an,       4'b1011);
        check("dis_pre_rdy", ld_ready, 1'b0);
        en = 1'b0;
        step();
        check("dis_an",  an,         4'b1111);
        check("dis_seg", seg,        7'h00);
        check("dis_fd",  frame_done, 1'b0);
        check("dis_rdy", ld_ready,   1'b1);
        for (int i = 0; i < 30; i++) step();
        en = 1'b1;
        for (int i = 0; i < FR + SLOT; i++) step();

        // Asynchronous reset mid-show with data pending.
        advance_to(0);
        ld_valid = 1'b1;
        ld_data  = 16'h9999;
        step();
        ld_valid = 1'b0;
        advance_to(SLOT + BC + 1);
        check("ar_pre_rdy", ld_ready, 1'b0);
        check("ar_pre_an",  an,       4'b1101);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_an",  an,         4'b1111);
        check("ar_seg", seg,        7'h00);
        check("ar_rdy", ld_ready,   1'b1);
        check("ar_fd",  frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            if (an != 4'b1111) check("ar_zero_seg", seg, 7'h3F);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
